sync_fifo_param: RTL and testbench

- Parametrised synchronous single-clock FIFO; the next generation of the team's 8-bit/16-entry byte FIFO.
- Generalised in data width and depth. Depth is a power of two, and the FIFO holds all DEPTH entries.
- New features over the previous generation:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags.
- Sits between producer and consumer stages in the datapath. Replaces the fixed-size FIFO in new testbench/DUT pairs.

---
 rtl/sync_fifo_param_pkg.sv | 19 +
 rtl/sync_fifo_param_if.sv | 37 +++
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: counter width,
// read-mode selectors and the elaboration-time parameter sanity check.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two (>= 2) and both thresholds must lie in 0..DEPTH
    function automatic bit fifo_params_ok(input int depth, input int af_thresh, input int ae_thresh);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 0) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO; master is the surrounding
// datapath, slave is the FIFO itself.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = fifo_cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// FIFO storage array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of the location being written this cycle sees the old word
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read mode, programmable almost flags and sticky overflow/underflow errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    if (!fifo_params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: DEPTH must be a power of two >= 2 and thresholds within 0..DEPTH");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occupancy;
    logic              overflow_flag;
    logic              underflow_flag;
    logic              is_empty;
    logic              is_full;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] head_data;

    // Status is decoded from the registered occupancy, never from the pointers
    assign is_empty = (occupancy == '0);
    assign is_full  = (occupancy == CW'(DEPTH));

    assign rd_acc = bus.rd_en && !is_empty;
    assign wr_acc = bus.wr_en && (!is_full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occupancy      <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occupancy      <= occupancy + CW'(wr_acc) - CW'(rd_acc);
            overflow_flag  <= (overflow_flag && !bus.clr_err) || (bus.wr_en && !wr_acc);
            underflow_flag <= (underflow_flag && !bus.clr_err) || (bus.rd_en && !rd_acc);
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign bus.rd_data  = head_data;
        assign bus.rd_valid = !is_empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_reg;
        logic              rd_valid_reg;

        // Output register holds the last popped word; valid pulses for one cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_acc;
                if (rd_acc) begin
                    rd_data_reg <= head_data;
                end
            end
        end

        assign bus.rd_data  = rd_data_reg;
        assign bus.rd_valid = rd_valid_reg;
    end

    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (int'(occupancy) >= AF_THRESH);
    assign bus.almost_empty = (int'(occupancy) <= AE_THRESH);
    assign bus.count        = occupancy;
    assign bus.overflow     = overflow_flag;
    assign bus.underflow    = underflow_flag;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO receive identical
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) std_bus ();
    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fwft_bus ();

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(MODE_STD)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (std_bus)
    );

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(MODE_FWFT)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (fwft_bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue, plus standard-mode output register
    logic [7:0] model_q [$];
    bit         m_ov;
    bit         m_un;
    bit         m_rv;
    logic [7:0] m_rd;

    typedef struct {
        bit         wr;
        logic [7:0] data;
        bit         rd;
        bit         clr;
        bit         rs;
        int         e_count;
        bit         e_empty;
        bit         e_un;
        bit         e_rv;
        logic [7:0] e_rd;
    } vec_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
        bit rd_ok;
        bit wr_ok;
        if (rs) begin
            model_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rv = 1'b0;
            m_rd = 8'h00;
        end else begin
            rd_ok = r && (model_q.size() != 0);
            wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
            m_ov = (m_ov && !c) || (w && !wr_ok);
            m_un = (m_un && !c) || (r && !rd_ok);
        end
    endtask

    // Drive one cycle of inputs on both FIFOs, step the model at the edge, settle
    task automatic apply_stimulus(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
        std_bus.wr_en    = w;
        std_bus.wr_data  = d;
        std_bus.rd_en    = r;
        std_bus.clr_err  = c;
        fwft_bus.wr_en   = w;
        fwft_bus.wr_data = d;
        fwft_bus.rd_en   = r;
        fwft_bus.clr_err = c;
        rst              = rs;
        @(posedge clk);
        model_update(w, d, r, c, rs);
        #1;
    endtask

    task automatic check_output(input string tag);
        int n;
        n = model_q.size();
        cmp({tag, " std.count"},        32'(std_bus.count),        32'(n));
        cmp({tag, " std.full"},         32'(std_bus.full),         32'(n == DEPTH));
        cmp({tag, " std.empty"},        32'(std_bus.empty),        32'(n == 0));
        cmp({tag, " std.almost_full"},  32'(std_bus.almost_full),  32'(n >= AF));
        cmp({tag, " std.almost_empty"}, 32'(std_bus.almost_empty), 32'(n <= AE));
        cmp({tag, " std.overflow"},     32'(std_bus.overflow),     32'(m_ov));
        cmp({tag, " std.underflow"},    32'(std_bus.underflow),    32'(m_un));
        cmp({tag, " std.rd_valid"},     32'(std_bus.rd_valid),     32'(m_rv));
        cmp({tag, " std.rd_data"},      32'(std_bus.rd_data),      32'(m_rd));
        cmp({tag, " fwft.count"},       32'(fwft_bus.count),       32'(n));
        cmp({tag, " fwft.overflow"},    32'(fwft_bus.overflow),    32'(m_ov));
        cmp({tag, " fwft.underflow"},   32'(fwft_bus.underflow),   32'(m_un));
        cmp({tag, " fwft.rd_valid"},    32'(fwft_bus.rd_valid),    32'(n != 0));
        if (n != 0) begin
            cmp({tag, " fwft.rd_data"}, 32'(fwft_bus.rd_data),     32'(model_q[0]));
        end
    endtask

    initial begin
        vec_t vecs [10];
        bit   w;
        bit   r;
        bit   c;
        bit   rs;
        int   wr_bias;

        std_bus.wr_en    = 1'b0;
        std_bus.wr_data  = '0;
        std_bus.rd_en    = 1'b0;
        std_bus.clr_err  = 1'b0;
        fwft_bus.wr_en   = 1'b0;
        fwft_bus.wr_data = '0;
        fwft_bus.rd_en   = 1'b0;
        fwft_bus.clr_err = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
        m_rv = 1'b0;
        m_rd = 8'h00;

        //            wr  data   rd  clr rs  cnt emp un  rv  rd_data
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[5] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[9] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h33};

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr, vecs[i].rs);
            cmp($sformatf("vec%0d count", i),     32'(std_bus.count),     32'(vecs[i].e_count));
            cmp($sformatf("vec%0d empty", i),     32'(std_bus.empty),     32'(vecs[i].e_empty));
            cmp($sformatf("vec%0d underflow", i), 32'(std_bus.underflow), 32'(vecs[i].e_un));
            cmp($sformatf("vec%0d rd_valid", i),  32'(std_bus.rd_valid),  32'(vecs[i].e_rv));
            cmp($sformatf("vec%0d rd_data", i),   32'(std_bus.rd_data),   32'(vecs[i].e_rd));
            check_output($sformatf("vec%0d", i));
        end

        // Fill 0x01..0x10, then one rejected write
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            cmp($sformatf("fill%0d almost_full", i), 32'(std_bus.almost_full), 32'(i >= 14));
            cmp($sformatf("fill%0d full", i),        32'(std_bus.full),        32'(i == 16));
            check_output("fill");
        end
        cmp("fill overflow clear", 32'(std_bus.overflow), 32'd0);
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cmp("write-when-full overflow", 32'(std_bus.overflow), 32'd1);
        cmp("write-when-full count",    32'(std_bus.count),    32'd16);
        check_output("ovf");

        // Drain in order with one-cycle latency
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cmp($sformatf("drain%0d rd_data", i),      32'(std_bus.rd_data),      32'(i));
            cmp($sformatf("drain%0d rd_valid", i),     32'(std_bus.rd_valid),     32'd1);
            cmp($sformatf("drain%0d almost_empty", i), 32'(std_bus.almost_empty), 32'((16 - i) <= 2));
            check_output("drain");
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cmp("drain idle rd_valid", 32'(std_bus.rd_valid), 32'd0);
        cmp("drain idle empty",    32'(std_bus.empty),    32'd1);
        check_output("drain idle");

        // Simultaneous read and write while full
        for (int i = 1; i <= 16; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        cmp("full rw count",    32'(std_bus.count),    32'd16);
        cmp("full rw full",     32'(std_bus.full),     32'd1);
        cmp("full rw rd_data",  32'(std_bus.rd_data),  32'h01);
        cmp("full rw overflow", 32'(std_bus.overflow), 32'd0);
        check_output("full rw");
        for (int i = 2; i <= 17; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cmp($sformatf("full rw drain%0d", i), 32'(std_bus.rd_data), (i == 17) ? 32'h55 : 32'(i));
            check_output("full rw drain");
        end

        // Simultaneous read and write while empty
        apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        cmp("empty rw count",       32'(std_bus.count),      32'd1);
        cmp("empty rw underflow",   32'(std_bus.underflow),  32'd1);
        cmp("empty rw fwft data",   32'(fwft_bus.rd_data),   32'h3C);
        check_output("empty rw");
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cmp("clr_err underflow", 32'(std_bus.underflow), 32'd0);
        check_output("clr");
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cmp("empty rw readback", 32'(std_bus.rd_data), 32'h3C);
        check_output("empty rw readback");

        // FWFT fall-through and pop
        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cmp("fwft fall rd_valid", 32'(fwft_bus.rd_valid), 32'd1);
        cmp("fwft fall rd_data",  32'(fwft_bus.rd_data),  32'hA5);
        check_output("fwft fall");
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cmp("fwft pop empty",    32'(fwft_bus.empty),    32'd1);
        cmp("fwft pop rd_valid", 32'(fwft_bus.rd_valid), 32'd0);
        check_output("fwft pop");

        // Reset in the middle of a burst
        apply_stimulus(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        cmp("mid rst count",     32'(std_bus.count),     32'd0);
        cmp("mid rst empty",     32'(std_bus.empty),     32'd1);
        cmp("mid rst rd_valid",  32'(std_bus.rd_valid),  32'd0);
        cmp("mid rst overflow",  32'(std_bus.overflow),  32'd0);
        cmp("mid rst underflow", 32'(std_bus.underflow), 32'd0);
        check_output("mid rst");
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cmp("post rst readback", 32'(std_bus.rd_data), 32'h77);
        check_output("post rst");

        // Randomised traffic with phases that favour filling or draining
        for (int cyc = 0; cyc < 2000; cyc++) begin
            wr_bias = ((cyc / 150) % 2 == 0) ? 70 : 30;
            w  = ($urandom_range(99) < wr_bias);
            r  = ($urandom_range(99) < (100 - wr_bias));
            c  = ($urandom_range(31) == 0);
            rs = ($urandom_range(255) == 0);
            apply_stimulus(w, 8'($urandom), r, c, rs);
            check_output("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
